idu1_scoreboard: RTL

Parametrised successor to the IDU1 issue stage. It holds one decoded instruction and reads operands from an external register file. Operands are forwarded from NUM_WB writeback ports, and a per-register tag scoreboard detects RAW hazards on long-latency results. Issue to EXU uses a valid/ready handshake and is gated by per-unit busy. It sits between IDU0 and the EXU, replacing the fixed single-port forwarding and the mul/div/lsu-specific stall logic.

---
 rtl/idu1_scoreboard_pkg.sv | 15 +
 rtl/idu1_sb_table.sv | 46 ++++
 rtl/idu1_scoreboard.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/idu1_scoreboard_pkg.sv
// idu1_scoreboard_pkg: unit one-hot codes, width defaults and the holding-register control struct
package idu1_scoreboard_pkg;
  localparam int RA_W_DEF = 5;
  localparam int TAG_W_DEF = 4;
  localparam logic [3:0] UNIT_ALU = 4'b0001;
  localparam logic [3:0] UNIT_MUL = 4'b0010;
  localparam logic [3:0] UNIT_DIV = 4'b0100;
  localparam logic [3:0] UNIT_LSU = 4'b1000;
  typedef struct packed {
    logic valid;
    logic rd_en;
    logic op1_rdy;
    logic op2_rdy;
  } idu1_sb_hold_t;
endpackage

// File: rtl/idu1_sb_table.sv
// idu1_sb_table: per-register pending bit and owner tag; set on issue, cleared by a tag-matching writeback (set wins), two read lookups
module idu1_sb_table
  import idu1_scoreboard_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int RA_W = RA_W_DEF,
  parameter int TAG_W = TAG_W_DEF,
  parameter int NUM_WB = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    set_en,
  input  logic [RA_W-1:0]         set_addr,
  input  logic [TAG_W-1:0]        set_tag,
  input  logic [NUM_WB-1:0]       clr_valid,
  input  logic [NUM_WB*RA_W-1:0]  clr_addr,
  input  logic [NUM_WB*TAG_W-1:0] clr_tag,
  input  logic [RA_W-1:0]         rs1_addr,
  input  logic [RA_W-1:0]         rs2_addr,
  output logic                    rs1_pending,
  output logic                    rs2_pending,
  output logic [TAG_W-1:0]        rs1_owner,
  output logic [TAG_W-1:0]        rs2_owner,
  output logic [NUM_REGS-1:0]     pending
);
  logic [TAG_W-1:0] owner [NUM_REGS];
  assign rs1_pending = pending[rs1_addr];
  assign rs2_pending = pending[rs2_addr];
  assign rs1_owner = owner[rs1_addr];
  assign rs2_owner = owner[rs2_addr];
  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= '0;
      for (int r = 0; r < NUM_REGS; r++) owner[r] <= '0;
    end else begin
      for (int p = 0; p < NUM_WB; p++)
        if (clr_valid[p] && pending[clr_addr[p*RA_W +: RA_W]] &&
            clr_tag[p*TAG_W +: TAG_W] == owner[clr_addr[p*RA_W +: RA_W]])
          pending[clr_addr[p*RA_W +: RA_W]] <= 1'b0;
      if (set_en && set_addr != '0) begin
        pending[set_addr] <= 1'b1;
        owner[set_addr] <= set_tag;
      end
    end
  end
endmodule

// File: rtl/idu1_scoreboard.sv
// idu1_scoreboard: one-entry issue stage (dec_* in, rf_* read, wb_* forward/capture, iss_* valid/ready out, unit_busy gate, sb_pending debug)
module idu1_scoreboard
  import idu1_scoreboard_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NUM_REGS = 32,
  parameter int NUM_WB = 2,
  parameter int TAG_W = TAG_W_DEF,
  parameter int NUM_UNITS = 4,
  parameter int PAYLOAD_W = 64,
  localparam int RA_W = $clog2(NUM_REGS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    dec_valid,
  output logic                    dec_ready,
  input  logic                    dec_rs1_en,
  input  logic                    dec_rs2_en,
  input  logic [RA_W-1:0]         dec_rs1_addr,
  input  logic [RA_W-1:0]         dec_rs2_addr,
  input  logic                    dec_rd_en,
  input  logic [RA_W-1:0]         dec_rd_addr,
  input  logic [NUM_UNITS-1:0]    dec_unit,
  input  logic [TAG_W-1:0]        dec_tag,
  input  logic [PAYLOAD_W-1:0]    dec_payload,
  output logic [RA_W-1:0]         rf_rs1_addr,
  output logic [RA_W-1:0]         rf_rs2_addr,
  input  logic [XLEN-1:0]         rf_rs1_data,
  input  logic [XLEN-1:0]         rf_rs2_data,
  input  logic [NUM_WB-1:0]       wb_valid,
  input  logic [NUM_WB*RA_W-1:0]  wb_rd_addr,
  input  logic [NUM_WB*TAG_W-1:0] wb_tag,
  input  logic [NUM_WB*XLEN-1:0]  wb_data,
  input  logic [NUM_UNITS-1:0]    unit_busy,
  output logic                    iss_valid,
  input  logic                    iss_ready,
  output logic [XLEN-1:0]         iss_rs1_data,
  output logic [XLEN-1:0]         iss_rs2_data,
  output logic                    iss_rd_en,
  output logic [RA_W-1:0]         iss_rd_addr,
  output logic [NUM_UNITS-1:0]    iss_unit,
  output logic [TAG_W-1:0]        iss_tag,
  output logic [PAYLOAD_W-1:0]    iss_payload,
  output logic [NUM_REGS-1:0]     sb_pending
);
  idu1_sb_hold_t h;
  logic [RA_W-1:0] rs1_q, rs2_q;
  logic [TAG_W-1:0] own1_q, own2_q, sb_own1, sb_own2;
  logic [XLEN-1:0] op1_q, op2_q, ld1, ld2;
  logic [XLEN:0] a1, a2, b1, b2;
  logic sb_pend1, sb_pend2, z1, z2, hz1, hz2, ld1_rdy, ld2_rdy, hit1, hit2, issue_fire;
  function automatic logic [XLEN:0] wb_pick(
    input logic [RA_W-1:0] a, input logic chk, input logic [TAG_W-1:0] t,
    input logic [NUM_WB-1:0] v, input logic [NUM_WB*RA_W-1:0] ra,
    input logic [NUM_WB*TAG_W-1:0] tg, input logic [NUM_WB*XLEN-1:0] d);
    wb_pick = '0;
    for (int p = NUM_WB - 1; p >= 0; p--)
      if (v[p] && ra[p*RA_W +: RA_W] == a && (!chk || tg[p*TAG_W +: TAG_W] == t))
        wb_pick = {1'b1, d[p*XLEN +: XLEN]};
  endfunction
  assign rf_rs1_addr = dec_rs1_addr;
  assign rf_rs2_addr = dec_rs2_addr;
  assign iss_rd_en = h.rd_en;
  always_comb begin
    a1 = wb_pick(dec_rs1_addr, 1'b0, '0, wb_valid, wb_rd_addr, wb_tag, wb_data);
    a2 = wb_pick(dec_rs2_addr, 1'b0, '0, wb_valid, wb_rd_addr, wb_tag, wb_data);
    b1 = wb_pick(rs1_q, 1'b1, own1_q, wb_valid, wb_rd_addr, wb_tag, wb_data);
    b2 = wb_pick(rs2_q, 1'b1, own2_q, wb_valid, wb_rd_addr, wb_tag, wb_data);
    hit1 = h.valid & ~h.op1_rdy & b1[XLEN];
    hit2 = h.valid & ~h.op2_rdy & b2[XLEN];
    iss_rs1_data = hit1 ? b1[XLEN-1:0] : op1_q;
    iss_rs2_data = hit2 ? b2[XLEN-1:0] : op2_q;
    iss_valid = h.valid & (h.op1_rdy | hit1) & (h.op2_rdy | hit2) & ~|(iss_unit & unit_busy) & ~flush;
    issue_fire = iss_valid & iss_ready;
    dec_ready = ~h.valid | issue_fire | flush;
    z1 = ~dec_rs1_en | (dec_rs1_addr == '0);
    z2 = ~dec_rs2_en | (dec_rs2_addr == '0);
    hz1 = issue_fire & h.rd_en & (iss_rd_addr == dec_rs1_addr);
    hz2 = issue_fire & h.rd_en & (iss_rd_addr == dec_rs2_addr);
    ld1_rdy = z1 | (~hz1 & (a1[XLEN] | ~sb_pend1));
    ld2_rdy = z2 | (~hz2 & (a2[XLEN] | ~sb_pend2));
    ld1 = z1 ? '0 : a1[XLEN] ? a1[XLEN-1:0] : rf_rs1_data;
    ld2 = z2 ? '0 : a2[XLEN] ? a2[XLEN-1:0] : rf_rs2_data;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      h <= '0;
      rs1_q <= '0;
      rs2_q <= '0;
      own1_q <= '0;
      own2_q <= '0;
      op1_q <= '0;
      op2_q <= '0;
      iss_rd_addr <= '0;
      iss_unit <= '0;
      iss_tag <= '0;
      iss_payload <= '0;
    end else if (flush) begin
      h.valid <= 1'b0;
    end else if (dec_valid && dec_ready) begin
      h <= '{valid: 1'b1, rd_en: dec_rd_en, op1_rdy: ld1_rdy, op2_rdy: ld2_rdy};
      rs1_q <= dec_rs1_addr;
      rs2_q <= dec_rs2_addr;
      own1_q <= hz1 ? iss_tag : sb_own1;
      own2_q <= hz2 ? iss_tag : sb_own2;
      op1_q <= ld1;
      op2_q <= ld2;
      iss_rd_addr <= dec_rd_addr;
      iss_unit <= dec_unit;
      iss_tag <= dec_tag;
      iss_payload <= dec_payload;
    end else begin
      if (issue_fire) h.valid <= 1'b0;
      if (hit1) begin
        op1_q <= b1[XLEN-1:0];
        h.op1_rdy <= 1'b1;
      end
      if (hit2) begin
        op2_q <= b2[XLEN-1:0];
        h.op2_rdy <= 1'b1;
      end
    end
  end
  idu1_sb_table #(.NUM_REGS(NUM_REGS), .RA_W(RA_W), .TAG_W(TAG_W), .NUM_WB(NUM_WB)) u_table (
    .clk(clk),
    .rst(rst),
    .set_en(issue_fire & h.rd_en),
    .set_addr(iss_rd_addr),
    .set_tag(iss_tag),
    .clr_valid(wb_valid),
    .clr_addr(wb_rd_addr),
    .clr_tag(wb_tag),
    .rs1_addr(dec_rs1_addr),
    .rs2_addr(dec_rs2_addr),
    .rs1_pending(sb_pend1),
    .rs2_pending(sb_pend2),
    .rs1_owner(sb_own1),
    .rs2_owner(sb_own2),
    .pending(sb_pending)
  );
endmodule
